// File: rtl/sub_div_ctrl.sv
// rtl/sub_div_ctrl.sv - restoring-by-subtraction 4-bit divider controller driving an external subtractor
module sub_div_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] sub_a,
    output logic [3:0] sub_b,
    input  logic [3:0] sub_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_rem;
    logic [3:0] r_div;
    logic [3:0] r_quot;
    logic       r_dbz;
    logic       w_accept;
    logic       w_zero_div;
    logic       w_ge;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_zero_div = (B == 4'd0);
    assign w_ge       = (r_rem >= r_div);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_zero_div ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (!w_ge) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_CALC: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath; a zero divisor skips CALC and reports an all-ones quotient
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= 4'd0;
            r_div  <= 4'd0;
            r_quot <= 4'd0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_rem  <= A;
            r_div  <= B;
            r_quot <= w_zero_div ? 4'hF : 4'd0;
            r_dbz  <= w_zero_div;
        end else if ((r_state == S_CALC) && w_ge) begin
            r_rem  <= sub_y;
            r_quot <= r_quot + 4'd1;
        end
    end

    assign sub_a       = r_rem;
    assign sub_b       = r_div;
    assign Q           = r_quot;
    assign R           = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_sub_div_ctrl.sv
// tb/tb_sub_div_ctrl.sv - scoreboard bench for sub_div_ctrl
module tb_sub_div_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] sub_a;
    logic [3:0] sub_b;
    logic [3:0] sub_y;
    logic       busy;
    logic       done;
    logic [3:0] Q;
    logic [3:0] R;
    logic       div_by_zero;

    sub_div_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .sub_a       (sub_a),
        .sub_b       (sub_b),
        .sub_y       (sub_y),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
    );

    // External subtraction unit
    assign sub_y = sub_a - sub_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         acc;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;
    int   busy_cnt;
    logic prev_done;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    initial begin
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (prev_done) begin
                        checks++;
                        errors++;
                        $display("FAIL done_width: actual=2+ cycles required=1 cycle (t=%0t)", $time);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: actual=1 required=0 (t=%0t)", $time);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("Q", Q, e.q);
                        chk("R", R, e.r);
                        chk("div_by_zero", div_by_zero, e.dbz);
                        chk("done_latency", cyc - e.acc + 1, e.lat);
                        chk("busy_cycles", busy_cnt, e.lat);
                    end
                    busy_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: actual=busy required=idle", name);
        end
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                       input logic [3:0] er, input logic ed, input int lat);
        exp_t e;
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        e.q = eq; e.r = er; e.dbz = ed; e.acc = cyc + 1; e.lat = lat;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_idle("run");
    endtask

    initial begin
        exp_t e;
        int   n;
        checks = 0;
        errors = 0;
        start  = 1'b0;
        A      = 4'd0;
        B      = 4'd0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_Q", Q, 0);
        chk("rst_R", R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_sub_a", sub_a, 0);
        chk("rst_sub_b", sub_b, 0);
        rst_n = 1'b1;

        run(4'd7,  4'd3, 4'd2,  4'd1, 1'b0, 4);
        run(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 17);
        run(4'd9,  4'd0, 4'hF,  4'd9, 1'b1, 1);
        run(4'd5,  4'd9, 4'd0,  4'd5, 1'b0, 2);
        run(4'd5,  4'd5, 4'd1,  4'd0, 1'b0, 3);
        run(4'd0,  4'd7, 4'd0,  4'd0, 1'b0, 2);

        // start held high across CALC/DONE: only the IDLE edge after DONE starts again
        @(negedge clk);
        A = 4'd12; B = 4'd4; start = 1'b1;
        e.q = 4'd3; e.r = 4'd0; e.dbz = 1'b0; e.acc = cyc + 1; e.lat = 5;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL held_timeout: actual=no done required=done");
        end
        e.acc = cyc + 2;
        exp_q.push_back(e);
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle("held");

        // Reset during CALC aborts the division
        @(negedge clk);
        A = 4'd14; B = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_Q", Q, 0);
        chk("abort_R", R, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
